// File: rtl/arm_instr_encoder_if.sv
// Request/stream bundle between the program generator, the ARM instruction
// encoder and the imem loader. The master modport is the generator/loader
// side, the slave modport is the encoder itself.
interface arm_instr_encoder_if #(
  parameter int DEPTH = 4
);
  // request side
  logic                         in_valid;
  logic                         in_ready;
  logic [1:0]                   in_class;
  logic [3:0]                   in_cond;
  logic [3:0]                   in_cmd;
  logic                         in_i;
  logic                         in_s;
  logic                         in_l;
  logic [3:0]                   in_rn;
  logic [3:0]                   in_rd;
  logic [3:0]                   in_rm;
  logic [23:0]                  in_imm;
  // encoded word stream
  logic                         out_valid;
  logic                         out_ready;
  logic [31:0]                  out_instr;
  logic [31:0]                  out_addr;
  // status
  logic                         err;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output in_valid, in_class, in_cond, in_cmd, in_i, in_s, in_l,
           in_rn, in_rd, in_rm, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, count
  );

  modport slave (
    input  in_valid, in_class, in_cond, in_cmd, in_i, in_s, in_l,
           in_rn, in_rd, in_rm, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, count
  );
endinterface

// File: rtl/arm_instr_encoder.sv
// ARM instruction encoder: packs field-level requests into 32-bit DP,
// LDR/STR and B words, tags each with its imem byte address and queues
// them in a small FIFO towards the imem loader. Illegal requests are
// swallowed and flagged on the sticky err output.
// Build option: define ENC_PC_REL_EN to treat the branch immediate as an
// absolute byte target and convert it to a PC-relative word offset.
module arm_instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MEM_WORDS = 64
) (
  input logic                 clk,
  input logic                 reset_n,
  arm_instr_encoder_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // FIFO storage (no reset needed: only entries below count are ever read)
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   addr_mem  [DEPTH];

  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          out_valid_reg;
  logic [31:0]   out_instr_reg, out_addr_reg;
  logic [31:0]   wr_addr_reg;
  logic [IW-1:0] word_idx_reg;
  logic          err_reg;

  logic          legal;
  logic [31:0]   enc_word;
  logic [23:0]   br_imm24;
  logic          in_ready_int, accept, push, pop;
  logic [PW-1:0] rd_ptr_next;
  logic [CW-1:0] count_next;
  logic [31:0]   head_instr_next, head_addr_next;

`ifdef ENC_PC_REL_EN
  // Branch offset is relative to PC+8 of the branch itself, in words.
  logic [31:0] br_diff;
  assign br_diff  = {8'h00, bus.in_imm} - (wr_addr_reg + 32'd8);
  assign br_imm24 = 24'(br_diff >> 2);
`else
  assign br_imm24 = bus.in_imm;
`endif

  // Field packing and legality check for the current request.
  always_comb begin
    legal    = 1'b1;
    enc_word = 32'h0;
    case (bus.in_class)
      2'b00: begin
        case (bus.in_cmd)
          4'b0100, 4'b0010, 4'b0000, 4'b1100: legal = 1'b1;
          default:                            legal = 1'b0;
        endcase
        enc_word = {bus.in_cond, 2'b00, bus.in_i, bus.in_cmd, bus.in_s,
                    bus.in_rn, bus.in_rd,
                    bus.in_i ? bus.in_imm[11:0] : {8'h00, bus.in_rm}};
      end
      2'b01: enc_word = {bus.in_cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                         bus.in_l, bus.in_rn, bus.in_rd, bus.in_imm[11:0]};
      2'b10: enc_word = {bus.in_cond, 4'b1010, br_imm24};
      default: legal = 1'b0;
    endcase
  end

  // Handshakes, occupancy and the next head of the queue.
  always_comb begin
    in_ready_int = (count_reg < CW'(DEPTH)) | (out_valid_reg & bus.out_ready);
    accept       = bus.in_valid & in_ready_int;
    push         = accept & legal;
    pop          = out_valid_reg & bus.out_ready;
    rd_ptr_next  = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
    count_next   = count_reg;
    if (push && !pop)      count_next = count_reg + CW'(1);
    else if (!push && pop) count_next = count_reg - CW'(1);
    // A word written this edge into the slot that becomes the head must be
    // forwarded, since the array only holds it after the edge.
    if (push && (wr_ptr_reg == rd_ptr_next)) begin
      head_instr_next = enc_word;
      head_addr_next  = wr_addr_reg;
    end else begin
      head_instr_next = instr_mem[rd_ptr_next];
      head_addr_next  = addr_mem[rd_ptr_next];
    end
  end

  // FIFO array write on every pushed word.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= enc_word;
      addr_mem[wr_ptr_reg]  <= wr_addr_reg;
    end
  end

  // Pointers, occupancy, output register, address counter and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_instr_reg <= 32'h0;
      out_addr_reg  <= 32'h0;
      wr_addr_reg   <= BASE_ADDR;
      word_idx_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      out_valid_reg <= (count_next != '0);
      // Output holds its last value once the queue runs dry.
      if (count_next != '0) begin
        out_instr_reg <= head_instr_next;
        out_addr_reg  <= head_addr_next;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (word_idx_reg == IW'(MEM_WORDS - 1)) begin
          word_idx_reg <= '0;
          wr_addr_reg  <= BASE_ADDR;
        end else begin
          word_idx_reg <= word_idx_reg + IW'(1);
          wr_addr_reg  <= wr_addr_reg + 32'd4;
        end
      end
      if (accept && !legal) err_reg <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_instr = out_instr_reg;
  assign bus.out_addr  = out_addr_reg;
  assign bus.err       = err_reg;
  assign bus.count     = count_reg;
endmodule

// File: tb/tb_arm_instr_encoder.sv
// Self-checking bench for arm_instr_encoder: directed scenarios followed by
// a random request/backpressure stream, all checked cycle by cycle against
// a queue-based reference model.
module tb_arm_instr_encoder;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0;
  localparam int          MEM_WORDS = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  arm_instr_encoder_if #(.DEPTH(DEPTH)) bus ();

  arm_instr_encoder #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [63:0] q[$];
  logic [31:0] m_addr;
  int          m_words;
  logic        m_err;
  logic [31:0] last_i, last_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoding built directly from the field layout.
  function automatic void ref_enc(input logic [1:0] cls, input logic [3:0] cond,
                                  input logic [3:0] cmd, input logic i, input logic s,
                                  input logic l, input logic [3:0] rn, input logic [3:0] rd,
                                  input logic [3:0] rm, input logic [23:0] imm,
                                  input logic [31:0] addr,
                                  output logic [31:0] w, output bit ok);
    longint d;
    logic [31:0] off;
    w  = 32'h0;
    ok = 1'b1;
    if (cls == 2'd0) begin
      ok = (cmd == 4'd4) || (cmd == 4'd2) || (cmd == 4'd0) || (cmd == 4'd12);
      w  = (32'(cond) << 28) | (32'(i) << 25) | (32'(cmd) << 21) | (32'(s) << 20)
         | (32'(rn) << 16) | (32'(rd) << 12) | (i ? (32'(imm) & 32'hFFF) : 32'(rm));
    end else if (cls == 2'd1) begin
      w  = (32'(cond) << 28) | (32'd1 << 26) | (32'd1 << 24) | (32'd1 << 23)
         | (32'(l) << 20) | (32'(rn) << 16) | (32'(rd) << 12) | (32'(imm) & 32'hFFF);
    end else if (cls == 2'd2) begin
`ifdef ENC_PC_REL_EN
      d   = longint'(imm) - longint'(addr) - 64'sd8;
      d   = d >>> 2;
      off = 32'(d) & 32'h00FF_FFFF;
`else
      off = 32'(imm);
      d   = longint'(addr);
`endif
      w = (32'(cond) << 28) | (32'hA << 24) | off;
    end else begin
      ok = 1'b0;
    end
  endfunction

  task automatic model_reset();
    q.delete();
    m_addr  = BASE_ADDR;
    m_words = 0;
    m_err   = 1'b0;
    last_i  = 32'h0;
    last_a  = 32'h0;
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    check("count",     32'(bus.count),     32'(q.size()));
    check("err",       32'(bus.err),       32'(m_err));
    check("out_instr", bus.out_instr,      last_i);
    check("out_addr",  bus.out_addr,       last_a);
  endtask

  // One clock with the currently driven inputs; model advances alongside.
  task automatic step();
    bit exp_rdy, fire, pop, ok;
    logic [31:0] w;
    #1;
    exp_rdy = (q.size() < DEPTH) || ((q.size() != 0) && bus.out_ready);
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    fire = bus.in_valid && exp_rdy;
    pop  = (q.size() != 0) && bus.out_ready;
    ref_enc(bus.in_class, bus.in_cond, bus.in_cmd, bus.in_i, bus.in_s, bus.in_l,
            bus.in_rn, bus.in_rd, bus.in_rm, bus.in_imm, m_addr, w, ok);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (fire) begin
      if (ok) begin
        q.push_back({m_addr, w});
        m_words++;
        if (m_words == MEM_WORDS) begin
          m_words = 0;
          m_addr  = BASE_ADDR;
        end else begin
          m_addr = m_addr + 32'd4;
        end
      end else begin
        m_err = 1'b1;
      end
    end
    if (q.size() != 0) begin
      last_i = q[0][31:0];
      last_a = q[0][63:32];
    end
    check_outputs();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic set_dp(input logic [3:0] cmd, input logic i, input logic s,
                        input logic [3:0] rn, input logic [3:0] rd,
                        input logic [3:0] rm, input logic [23:0] imm);
    bus.in_valid = 1'b1; bus.in_class = 2'b00; bus.in_cond = 4'hE;
    bus.in_cmd = cmd; bus.in_i = i; bus.in_s = s; bus.in_l = 1'b0;
    bus.in_rn = rn; bus.in_rd = rd; bus.in_rm = rm; bus.in_imm = imm;
  endtask

  task automatic set_mem(input logic l, input logic [3:0] rn, input logic [3:0] rd,
                         input logic [23:0] imm);
    bus.in_valid = 1'b1; bus.in_class = 2'b01; bus.in_cond = 4'hE;
    bus.in_cmd = 4'h0; bus.in_i = 1'b0; bus.in_s = 1'b0; bus.in_l = l;
    bus.in_rn = rn; bus.in_rd = rd; bus.in_rm = 4'h0; bus.in_imm = imm;
  endtask

  task automatic set_br(input logic [23:0] imm);
    bus.in_valid = 1'b1; bus.in_class = 2'b10; bus.in_cond = 4'hE;
    bus.in_cmd = 4'h0; bus.in_i = 1'b0; bus.in_s = 1'b0; bus.in_l = 1'b0;
    bus.in_rn = 4'h0; bus.in_rd = 4'h0; bus.in_rm = 4'h0; bus.in_imm = imm;
  endtask

  task automatic do_reset();
    idle();
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    reset_n = 1'b1;
  endtask

  initial begin
    bit [3:0] cmds [4] = '{4'h4, 4'h2, 4'h0, 4'hC};
    set_dp(4'h4, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 24'h0);
    idle();

    // Reset state
    do_reset();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ADD R1,R2,#5 straight after reset
    bus.out_ready = 1'b1;
    set_dp(4'h4, 1'b1, 1'b0, 4'h2, 4'h1, 4'h0, 24'h5);
    step();
    check("add_word", bus.out_instr, 32'hE2821005);
    check("add_addr", bus.out_addr, 32'h0);
    idle(); step(); step();

    // SUB / LDR / STR queued, then drained
    do_reset();
    set_dp(4'h2, 1'b0, 1'b1, 4'h4, 4'h3, 4'h5, 24'h0); step();
    set_mem(1'b1, 4'h1, 4'h0, 24'h8); step();
    set_mem(1'b0, 4'h1, 4'h0, 24'h8); step();
    idle();
    check("sub_word", bus.out_instr, 32'hE0543005);
    bus.out_ready = 1'b1; step();
    check("ldr_word", bus.out_instr, 32'hE5910008);
    check("ldr_addr", bus.out_addr, 32'h4);
    step();
    check("str_word", bus.out_instr, 32'hE5810008);
    check("str_addr", bus.out_addr, 32'h8);
    step(); step();

    // Fill with no consumer, then push and pop in the same cycle
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_dp(4'hC, 1'b1, 1'b0, 4'h1, 4'(k), 4'h0, 24'(k));
      step();
    end
    check("full_count", 32'(bus.count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    step();
    check("pushpop_count", 32'(bus.count), 32'd4);
    idle();
    for (int k = 0; k < 5; k++) step();

    // Illegal DP command, then ADD lands at the base address
    do_reset();
    bus.out_ready = 1'b1;
    set_dp(4'hF, 1'b0, 1'b0, 4'h1, 4'h1, 4'h1, 24'h0); step();
    set_dp(4'h4, 1'b1, 1'b0, 4'h2, 4'h1, 4'h0, 24'h5); step();
    check("illegal_err", 32'(bus.err), 32'd1);
    check("after_illegal_addr", bus.out_addr, 32'h0);
    idle(); step(); step();
    check("err_sticky", 32'(bus.err), 32'd1);

    // Branch after four words
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_dp(4'h0, 1'b0, 1'b0, 4'h1, 4'h2, 4'h3, 24'h0); step();
    end
`ifdef ENC_PC_REL_EN
    set_br(24'h0); step();
    check("br_word", bus.out_instr, 32'hEAFFFFFA);
`else
    set_br(24'h000003); step();
    check("br_word", bus.out_instr, 32'hEA000003);
`endif
    check("br_addr", bus.out_addr, 32'h10);
    idle(); step();

    // Asynchronous reset with three words queued
    do_reset();
    set_dp(4'hF, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 24'h0); step();
    for (int k = 0; k < 3; k++) begin
      set_mem(1'b1, 4'h2, 4'(k), 24'(4 * k)); step();
    end
    idle();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_count", 32'(bus.count), 32'd0);
    check("async_err", 32'(bus.err), 32'd0);
    #2;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    set_mem(1'b0, 4'h3, 4'h4, 24'h10); step();
    check("post_reset_addr", bus.out_addr, BASE_ADDR);
    idle(); step();

    // Random stream with backpressure, illegal requests and address wrap
    for (int n = 0; n < 1200; n++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_class  = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      bus.in_cond   = 4'($urandom);
      bus.in_cmd    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : cmds[$urandom_range(0, 3)];
      bus.in_i      = 1'($urandom);
      bus.in_s      = 1'($urandom);
      bus.in_l      = 1'($urandom);
      bus.in_rn     = 4'($urandom);
      bus.in_rd     = 4'($urandom);
      bus.in_rm     = 4'($urandom);
      bus.in_imm    = 24'($urandom);
      step();
    end
    idle();
    bus.out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
